// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package riscv_pipe_pkg;

  localparam int unsigned CNT_W_DEF = 32;
  localparam logic [4:0]  REG_X0    = 5'd0;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
interface hazard_ctrl_if;

  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic       ex_memRead;
  logic [4:0] ex_rd;
  logic       ex_branch_taken;
  logic       mem_busy;
  logic       qed_vld_if_id;

  logic       pc_write;
  logic       if_id_write;
  logic       if_id_flush;
  logic       id_ex_write;
  logic       id_ex_bubble;
  logic       qed_vld_id;

  // Pipeline side: reports hazard sources, consumes control enables.
  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memRead, ex_rd,
           ex_branch_taken, mem_busy, qed_vld_if_id,
    input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
           qed_vld_id
  );

  // Controller side.
  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_memRead, ex_rd,
           ex_branch_taken, mem_busy, qed_vld_if_id,
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
           qed_vld_id
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  // Clear wins over increment; stop at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / branch-flush / memory-stall controller for the 5-stage core.
module hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  hazard_ctrl_if.slave     bus,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout,
  output logic [1:0]       state_o
);

  localparam int unsigned FC_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam int unsigned TO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  hz_state_t       state_q, state_d;
  logic [FC_W-1:0] fc_q, fc_d;
  logic [TO_W-1:0] to_cnt;

  logic lu;
  logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble;
  logic flush_inc, stall_inc, to_inc, to_clr;

  // State and flush-length register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      fc_q    <= fc_d;
    end
  end

  // Next state and Mealy control outputs; reset forces every control low.
  always_comb begin
    state_d      = state_q;
    fc_d         = fc_q;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b0;
    id_ex_bubble = 1'b0;
    flush_inc    = 1'b0;
    to_clr       = 1'b0;

    lu = bus.ex_memRead && (bus.ex_rd != REG_X0) &&
         ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
          (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

    if (!reset) begin
      case (state_q)
        ST_RUN: begin
          if (bus.mem_busy) begin
            state_d = ST_MEM_WAIT;
          end else if (bus.ex_branch_taken) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_write  = 1'b1;
            id_ex_bubble = 1'b1;
            flush_inc    = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = ST_FLUSH;
              fc_d    = FC_W'(FLUSH_CYCLES - 1);
            end
          end else if (lu) begin
            id_ex_write  = 1'b1;
            id_ex_bubble = 1'b1;
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            id_ex_write = 1'b1;
          end
        end
        ST_FLUSH: begin
          if (!bus.mem_busy) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_write  = 1'b1;
            id_ex_bubble = 1'b1;
            fc_d         = fc_q - FC_W'(1);
            if (fc_q <= FC_W'(1)) begin
              state_d = ST_RUN;
            end
          end
        end
        ST_MEM_WAIT: begin
          if (!bus.mem_busy) begin
            state_d = ST_RUN;
            to_clr  = 1'b1;
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  assign bus.pc_write     = pc_write;
  assign bus.if_id_write  = if_id_write;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_write  = id_ex_write;
  assign bus.id_ex_bubble = id_ex_bubble;
  assign bus.qed_vld_id   = bus.qed_vld_if_id && id_ex_write && !id_ex_bubble;
  assign state_o          = state_q;

  assign stall_inc = !reset && !pc_write;
  assign to_inc    = (state_q == ST_MEM_WAIT);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .clr   (1'b0),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .clr   (1'b0),
    .cnt   (flush_cnt)
  );

  sat_counter #(.W(TO_W)) u_to_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (to_inc),
    .clr   (to_clr),
    .cnt   (to_cnt)
  );

  // Sticky timeout flag once a memory wait runs too long.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_timeout <= 1'b0;
    end else if ((state_q == ST_MEM_WAIT) && (to_cnt >= TO_W'(MEM_TIMEOUT))) begin
      mem_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with hand-computed expectations.
module tb_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic        mem_timeout;
  logic [1:0]  state_o;

  int errors;
  int checks;

  hazard_ctrl_if hif ();

  hazard_ctrl #(
    .FLUSH_CYCLES (2),
    .MEM_TIMEOUT  (255),
    .CNT_W        (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (hif.slave),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt),
    .mem_timeout (mem_timeout),
    .state_o     (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    hif.id_rs1          = 5'd0;
    hif.id_rs2          = 5'd0;
    hif.id_use_rs1      = 1'b0;
    hif.id_use_rs2      = 1'b0;
    hif.ex_memRead      = 1'b0;
    hif.ex_rd           = 5'd0;
    hif.ex_branch_taken = 1'b0;
    hif.mem_busy        = 1'b0;
    hif.qed_vld_if_id   = 1'b1;
  endtask

  task automatic set_lu();
    hif.ex_memRead = 1'b1;
    hif.ex_rd      = 5'd5;
    hif.id_use_rs1 = 1'b1;
    hif.id_rs1     = 5'd5;
  endtask

  task automatic check_ctrl_zero(input string tag);
    check({tag, ".pc_write"},     32'(hif.pc_write),     0);
    check({tag, ".if_id_write"},  32'(hif.if_id_write),  0);
    check({tag, ".id_ex_write"},  32'(hif.id_ex_write),  0);
    check({tag, ".if_id_flush"},  32'(hif.if_id_flush),  0);
    check({tag, ".id_ex_bubble"}, 32'(hif.id_ex_bubble), 0);
    check({tag, ".qed_vld_id"},   32'(hif.qed_vld_id),   0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    clear_in();
    #1;
    check_ctrl_zero("rst");
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst.state", 32'(state_o), 0);
    check("rst.stall_cnt", stall_cnt, 0);
    check("rst.flush_cnt", flush_cnt, 0);
    check("rst.mem_timeout", 32'(mem_timeout), 0);
    check("idle.pc_write", 32'(hif.pc_write), 1);
    check("idle.qed_vld_id", 32'(hif.qed_vld_id), 1);

    // Load-use stall
    set_lu();
    #1;
    check("lu.pc_write", 32'(hif.pc_write), 0);
    check("lu.if_id_write", 32'(hif.if_id_write), 0);
    check("lu.id_ex_write", 32'(hif.id_ex_write), 1);
    check("lu.id_ex_bubble", 32'(hif.id_ex_bubble), 1);
    check("lu.qed_vld_id", 32'(hif.qed_vld_id), 0);
    tick();
    check("lu.stall_cnt", stall_cnt, 1);
    hif.ex_memRead = 1'b0;
    #1;
    check("lu_done.pc_write", 32'(hif.pc_write), 1);
    check("lu_done.if_id_write", 32'(hif.if_id_write), 1);
    check("lu_done.id_ex_bubble", 32'(hif.id_ex_bubble), 0);
    tick();

    // rs2 match also stalls
    clear_in();
    hif.ex_memRead = 1'b1;
    hif.ex_rd      = 5'd9;
    hif.id_use_rs2 = 1'b1;
    hif.id_rs2     = 5'd9;
    #1;
    check("lu2.pc_write", 32'(hif.pc_write), 0);
    tick();
    check("lu2.stall_cnt", stall_cnt, 2);

    // x0 destination never stalls
    clear_in();
    hif.ex_memRead = 1'b1;
    hif.id_use_rs1 = 1'b1;
    #1;
    check("x0.pc_write", 32'(hif.pc_write), 1);
    check("x0.id_ex_bubble", 32'(hif.id_ex_bubble), 0);
    tick();
    check("x0.stall_cnt", stall_cnt, 2);

    // Taken branch: two flush cycles
    clear_in();
    hif.ex_branch_taken = 1'b1;
    #1;
    check("br0.if_id_flush", 32'(hif.if_id_flush), 1);
    check("br0.pc_write", 32'(hif.pc_write), 1);
    check("br0.qed_vld_id", 32'(hif.qed_vld_id), 0);
    check("br0.state", 32'(state_o), 0);
    tick();
    hif.ex_branch_taken = 1'b0;
    #1;
    check("br1.state", 32'(state_o), 1);
    check("br1.if_id_flush", 32'(hif.if_id_flush), 1);
    check("br1.flush_cnt", flush_cnt, 1);
    tick();
    check("br2.state", 32'(state_o), 0);
    check("br2.if_id_flush", 32'(hif.if_id_flush), 0);
    check("br2.flush_cnt", flush_cnt, 1);

    // Branch beats load-use
    hif.ex_branch_taken = 1'b1;
    set_lu();
    #1;
    check("prio.if_id_flush", 32'(hif.if_id_flush), 1);
    check("prio.pc_write", 32'(hif.pc_write), 1);
    tick();
    check("prio.flush_cnt", flush_cnt, 2);
    check("prio.stall_cnt", stall_cnt, 2);
    check("prio.state", 32'(state_o), 1);
    clear_in();
    tick();
    check("prio.back_run", 32'(state_o), 0);

    // mem_busy beats branch and load-use
    hif.ex_branch_taken = 1'b1;
    hif.mem_busy        = 1'b1;
    set_lu();
    #1;
    check_ctrl_zero("busy");
    tick();
    check("busy.state", 32'(state_o), 2);
    check("busy.stall_cnt", stall_cnt, 3);
    check("busy.flush_cnt", flush_cnt, 2);
    clear_in();
    #1;
    check("busy_exit.pc_write", 32'(hif.pc_write), 0);
    tick();
    check("busy_exit.state", 32'(state_o), 0);
    check("busy_exit.stall_cnt", stall_cnt, 4);

    // Three busy cycles cost four stalled cycles
    for (int i = 0; i < 4; i++) begin
      hif.mem_busy = (i < 3);
      #1;
      check("mw.pc_write", 32'(hif.pc_write), 0);
      tick();
    end
    hif.mem_busy = 1'b0;
    check("mw.state", 32'(state_o), 0);
    check("mw.stall_cnt", stall_cnt, 8);
    check("mw.pc_write_after", 32'(hif.pc_write), 1);

    // Long wait trips the sticky timeout
    hif.mem_busy = 1'b1;
    for (int i = 0; i < 250; i++) tick();
    check("to.early", 32'(mem_timeout), 0);
    for (int i = 0; i < 50; i++) tick();
    check("to.set", 32'(mem_timeout), 1);
    hif.mem_busy = 1'b0;
    tick();
    tick();
    tick();
    check("to.sticky", 32'(mem_timeout), 1);
    check("to.state", 32'(state_o), 0);
    check("to.stall_cnt", stall_cnt, 309);

    // Reset in FLUSH
    hif.ex_branch_taken = 1'b1;
    tick();
    hif.ex_branch_taken = 1'b0;
    check("rf.state_pre", 32'(state_o), 1);
    reset = 1'b1;
    #1;
    check_ctrl_zero("rf");
    tick();
    reset = 1'b0;
    #1;
    check("rf.state", 32'(state_o), 0);
    check("rf.stall_cnt", stall_cnt, 0);
    check("rf.flush_cnt", flush_cnt, 0);
    check("rf.mem_timeout", 32'(mem_timeout), 0);

    // Reset in MEM_WAIT
    hif.mem_busy = 1'b1;
    tick();
    tick();
    check("rm.state_pre", 32'(state_o), 2);
    reset = 1'b1;
    #1;
    check_ctrl_zero("rm");
    tick();
    reset = 1'b0;
    hif.mem_busy = 1'b0;
    #1;
    check("rm.state", 32'(state_o), 0);
    check("rm.stall_cnt", stall_cnt, 0);
    check("rm.pc_write", 32'(hif.pc_write), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
